// File: rtl/uart_cmd_master.sv
// Host-side command master for a UART register bridge: queues host requests, issues command
// words to the UART stage and returns read data with parity/timeout status.
`timescale 1ns/1ps
module uart_cmd_master #(
  parameter int unsigned CMD_WIDTH  = 16,
  parameter int unsigned READ_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_vld,
  output logic                              req_rdy,
  input  logic                              req_wr,
  input  logic [CMD_WIDTH-READ_WIDTH-2:0]   req_addr,
  input  logic [READ_WIDTH-1:0]             req_wdata,
  output logic [CMD_WIDTH-1:0]              cmd_in,
  output logic                              cmd_vld,
  input  logic                              cmd_rdy,
  input  logic                              read_rdy,
  input  logic [READ_WIDTH:0]               read_data,
  output logic                              resp_vld,
  input  logic                              resp_rdy,
  output logic [READ_WIDTH-1:0]             resp_data,
  output logic [1:0]                        resp_err,
  output logic                              busy,
  output logic                              stray_rd
);

  localparam int unsigned AW = CMD_WIDTH - READ_WIDTH - 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StSend, StWaitRd, StResp} state_e;

  state_e                  state_q, state_d;
  logic [CMD_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PW:0]             count_q;
  logic                    push, pop, full;
  logic [CMD_WIDTH-1:0]    head;
  logic [CMD_WIDTH-1:0]    cmd_in_q, cmd_in_d;
  logic                    cmd_vld_q, cmd_vld_d;
  logic                    resp_vld_q, resp_vld_d;
  logic [READ_WIDTH-1:0]   resp_data_q, resp_data_d;
  logic [1:0]              resp_err_q, resp_err_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    stray_rd_q;

  assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
  assign req_rdy = !full;
  assign push    = req_vld && req_rdy;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_wr, req_addr, req_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // cmd_vld rises one cycle after entering SEND, giving the two-edge request latency.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    cmd_in_d    = cmd_in_q;
    cmd_vld_d   = 1'b0;
    resp_vld_d  = 1'b0;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    timer_d     = timer_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop      = 1'b1;
          cmd_in_d = {~head[CMD_WIDTH-1], head[CMD_WIDTH-2 -: AW],
                      head[CMD_WIDTH-1] ? head[READ_WIDTH-1:0] : {READ_WIDTH{1'b0}}};
          state_d  = StSend;
        end
      end
      StSend: begin
        if (cmd_vld_q && cmd_rdy) begin
          timer_d = '0;
          state_d = cmd_in_q[CMD_WIDTH-1] ? StWaitRd : StIdle;
        end else begin
          cmd_vld_d = 1'b1;
        end
      end
      StWaitRd: begin
        if (read_rdy) begin
          resp_data_d = read_data[READ_WIDTH-1:0];
          resp_err_d  = (^read_data) ? 2'b00 : 2'b01;
          resp_vld_d  = 1'b1;
          state_d     = StResp;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          resp_data_d = '0;
          resp_err_d  = 2'b10;
          resp_vld_d  = 1'b1;
          state_d     = StResp;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (resp_rdy) state_d = StIdle;
        else          resp_vld_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cmd_in_q    <= '0;
      cmd_vld_q   <= 1'b0;
      resp_vld_q  <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 2'b00;
      timer_q     <= '0;
      stray_rd_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_in_q    <= cmd_in_d;
      cmd_vld_q   <= cmd_vld_d;
      resp_vld_q  <= resp_vld_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      timer_q     <= timer_d;
      if (read_rdy && state_q != StWaitRd) stray_rd_q <= 1'b1;
    end
  end

  assign cmd_in    = cmd_in_q;
  assign cmd_vld   = cmd_vld_q;
  assign resp_vld  = resp_vld_q;
  assign resp_data = resp_data_q;
  assign resp_err  = resp_err_q;
  assign stray_rd  = stray_rd_q;
  assign busy      = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed testbench for uart_cmd_master (TIMEOUT shortened to 20 cycles).
`timescale 1ns/1ps
module tb_uart_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0, req_wr = 1'b0;
  logic        req_rdy;
  logic [6:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [15:0] cmd_in;
  logic        cmd_vld;
  logic        cmd_rdy = 1'b0;
  logic        read_rdy = 1'b0;
  logic [8:0]  read_data = '0;
  logic        resp_vld;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp_data;
  logic [1:0]  resp_err;
  logic        busy, stray_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_cmd_master #(
    .CMD_WIDTH(16), .READ_WIDTH(8), .FIFO_DEPTH(4), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .cmd_in(cmd_in), .cmd_vld(cmd_vld),
    .cmd_rdy(cmd_rdy), .read_rdy(read_rdy), .read_data(read_data), .resp_vld(resp_vld),
    .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_err(resp_err), .busy(busy),
    .stray_rd(stray_rd)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle request; only used when the FIFO has room.
  task automatic issue(input logic wr, input logic [6:0] addr, input logic [7:0] wd);
    req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    tick();
    req_vld = 1'b0;
  endtask

  task automatic wait_cmd(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (cmd_vld) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Issues a read, completes the handshake, returns data 10 cycles later.
  task automatic run_read(input logic [6:0] addr, input logic [8:0] rd, output bit ok);
    cmd_rdy = 1'b1;
    issue(1'b0, addr, 8'hFF);
    wait_cmd(ok);
    tick();
    repeat (9) tick();
    read_rdy = 1'b1; read_data = rd;
    tick();
    read_rdy = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL reset_cmd_vld got %b want 0", cmd_vld); end
    checks++; if (cmd_in !== 16'h0) begin errors++; $display("FAIL reset_cmd_in got %h want 0000", cmd_in); end
    checks++; if (resp_vld !== 1'b0) begin errors++; $display("FAIL reset_resp_vld got %b want 0", resp_vld); end
    checks++; if (resp_data !== 8'h0 || resp_err !== 2'b00) begin
      errors++; $display("FAIL reset_resp got %h/%b want 00/00", resp_data, resp_err); end
    checks++; if (stray_rd !== 1'b0) begin errors++; $display("FAIL reset_stray got %b want 0", stray_rd); end
    checks++; if (req_rdy !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_rdy_busy got %b/%b want 1/0", req_rdy, busy); end
  endtask

  task automatic test_write();
    int hs = 0;
    bit saw_resp = 1'b0;
    cmd_rdy = 1'b1;
    issue(1'b1, 7'h12, 8'hA5);
    checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL wr_lat_n got %b want 0", cmd_vld); end
    tick();
    checks++; if (cmd_vld !== 1'b0) begin errors++; $display("FAIL wr_lat_n1 got %b want 0", cmd_vld); end
    tick();
    checks++; if (cmd_vld !== 1'b1) begin errors++; $display("FAIL wr_lat_n2 got %b want 1", cmd_vld); end
    checks++; if (cmd_in !== 16'h12A5) begin errors++; $display("FAIL wr_cmd_in got %h want 12a5", cmd_in); end
    for (int i = 0; i < 8; i++) begin
      if (cmd_vld && cmd_rdy) hs++;
      if (resp_vld) saw_resp = 1'b1;
      tick();
    end
    checks++; if (hs != 1) begin errors++; $display("FAIL wr_handshakes got %0d want 1", hs); end
    checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL wr_no_resp got %b want 0", saw_resp); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy got %b want 0", busy); end
  endtask

  task automatic test_read();
    bit ok;
    run_read(7'h05, 9'h13C, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_cmd_seen got 0 want 1"); end
    checks++; if (cmd_in !== 16'h8500) begin errors++; $display("FAIL rd_cmd_in got %h want 8500", cmd_in); end
    checks++; if (resp_vld !== 1'b1) begin errors++; $display("FAIL rd_resp_vld got %b want 1", resp_vld); end
    checks++; if (resp_data !== 8'h3C || resp_err !== 2'b00) begin
      errors++; $display("FAIL rd_resp got %h/%b want 3c/00", resp_data, resp_err); end
    tick();
    checks++; if (resp_vld !== 1'b1) begin errors++; $display("FAIL rd_resp_hold got %b want 1", resp_vld); end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
    checks++; if (resp_vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_release got %b/%b want 0/0", resp_vld, busy); end
  endtask

  task automatic test_parity();
    bit ok;
    run_read(7'h2A, 9'h03C, ok);
    checks++; if (!ok) begin errors++; $display("FAIL par_cmd_seen got 0 want 1"); end
    checks++; if (cmd_in !== 16'hAA00) begin errors++; $display("FAIL par_cmd_in got %h want aa00", cmd_in); end
    checks++; if (resp_vld !== 1'b1 || resp_data !== 8'h3C || resp_err !== 2'b01) begin
      errors++; $display("FAIL par_resp got %b/%h/%b want 1/3c/01", resp_vld, resp_data, resp_err); end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int k = 0;
    cmd_rdy = 1'b1;
    issue(1'b0, 7'h33, 8'h00);
    wait_cmd(ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_cmd_seen got 0 want 1"); end
    tick();
    while (!resp_vld && k < 40) begin
      tick();
      k++;
    end
    checks++; if (k != 20) begin errors++; $display("FAIL to_latency got %0d want 20", k); end
    checks++; if (resp_data !== 8'h00 || resp_err !== 2'b10) begin
      errors++; $display("FAIL to_resp got %h/%b want 00/10", resp_data, resp_err); end
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] got [6];
    int n = 0;
    bit pushing;
    cmd_rdy = 1'b0;
    for (int i = 0; i < 5; i++) issue(1'b1, 7'(i + 1), 8'(8'h10 + i));
    checks++; if (req_rdy !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", req_rdy); end
    req_vld = 1'b1; req_wr = 1'b1; req_addr = 7'h06; req_wdata = 8'h15;
    repeat (3) tick();
    checks++; if (req_rdy !== 1'b0 || cmd_in !== 16'h0110) begin
      errors++; $display("FAIL bp_stall got %b/%h want 0/0110", req_rdy, cmd_in); end
    cmd_rdy = 1'b1;
    for (int c = 0; c < 60 && n < 6; c++) begin
      pushing = req_vld && req_rdy;
      if (cmd_vld && cmd_rdy) begin
        got[n] = cmd_in;
        n++;
      end
      tick();
      if (pushing) req_vld = 1'b0;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL bp_count got %0d want 6", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== {1'b0, 7'(i + 1), 8'(8'h10 + i)}) begin
        errors++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], {1'b0, 7'(i + 1), 8'(8'h10 + i)});
      end
    end
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit saw_resp = 1'b0;
    cmd_rdy = 1'b0;
    issue(1'b0, 7'h01, 8'h00);
    wait_cmd(ok);
    #2 rst = 1'b1;
    #1;
    checks++; if (cmd_vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_send got %b/%b want 0/0", cmd_vld, busy); end
    tick();
    rst = 1'b0;
    cmd_rdy = 1'b1;
    issue(1'b0, 7'h02, 8'h00);
    wait_cmd(ok);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (resp_vld !== 1'b0 || cmd_vld !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_wait got %b/%b/%b want 0/0/0", resp_vld, cmd_vld, busy); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (resp_vld) saw_resp = 1'b1;
      tick();
    end
    checks++; if (saw_resp !== 1'b0) begin errors++; $display("FAIL rst_no_resp got %b want 0", saw_resp); end
    checks++; if (stray_rd !== 1'b0) begin errors++; $display("FAIL rst_stray_pre got %b want 0", stray_rd); end
    read_rdy = 1'b1; read_data = 9'h155;
    tick();
    read_rdy = 1'b0;
    checks++; if (stray_rd !== 1'b1 || resp_vld !== 1'b0) begin
      errors++; $display("FAIL rst_stray got %b/%b want 1/0", stray_rd, resp_vld); end
    repeat (2) tick();
    checks++; if (stray_rd !== 1'b1) begin errors++; $display("FAIL stray_sticky got %b want 1", stray_rd); end
  endtask

  initial begin
    #12;
    test_reset();
    rst = 1'b0;
    tick();
    test_write();
    test_read();
    test_parity();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
